// File: rtl/core_pkg.sv
// Shared load/store types: FSM state, access-size encodings, load funct3 codes
// and the size/alignment helpers used by the LSU.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_LOAD = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Loads carry their width in funct3; unknown codes behave as LW.
  function automatic logic [1:0] access_size(input logic [1:0] store_size,
                                             input logic [2:0] funct3);
    logic [1:0] sz;
    if (store_size != SZ_LOAD) begin
      sz = store_size;
    end else begin
      case (funct3)
        F3_LB, F3_LBU: sz = SZ_BYTE;
        F3_LH, F3_LHU: sz = SZ_HALF;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] lo);
    logic ok;
    case (sz)
      SZ_HALF: ok = ~lo[0];
      SZ_WORD: ok = (lo == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
interface load_store_unit_if #(parameter int ADDR_W = 32);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;

  modport master (output req, we, addr, be, wdata, input rdata, ack);
  modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module load_align
  import core_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{lane, 3'b000} +: 8];
    half_v = lane[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  data = {24'h0, byte_v};
      F3_LH:   data = {{16{half_v[15]}}, half_v};
      F3_LHU:  data = {16'h0, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one aligned access, holds it on the memory bus until
// ack, then spends one completion cycle; misaligned accesses fault in IDLE.
module load_store_unit
  import core_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              memory_en,
  input  logic [1:0]        store_size,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              misaligned,
  load_store_unit_if.master mem
);

  lsu_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_wdata;
  logic [2:0]        cap_f3;
  logic [1:0]        cap_size;
  logic              cap_is_load;
  logic              aligned;
  logic              accept;
  logic              in_req;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic [31:0]       ld_aligned;

  assign aligned     = is_aligned(access_size(store_size, funct3), addr[1:0]);
  assign cap_is_load = (cap_size == SZ_LOAD);
  assign in_req      = (state == REQ);

  // Core-facing strobes are held low while reset is asserted.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    stall      = 1'b0;
    misaligned = 1'b0;
    load_valid = 1'b0;
    case (state)
      IDLE: begin
        if (memory_en && RST_N) begin
          if (aligned) begin
            accept    = 1'b1;
            stall     = 1'b1;
            state_nxt = REQ;
          end else begin
            misaligned = 1'b1;
          end
        end
      end
      REQ: begin
        stall = RST_N;
        if (mem.ack) state_nxt = DONE;
      end
      DONE: begin
        load_valid = cap_is_load && RST_N;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    be = 4'hF;
    wd = cap_wdata;
    case (cap_size)
      SZ_BYTE: begin
        be = 4'b0001 << cap_addr[1:0];
        wd = {4{cap_wdata[7:0]}};
      end
      SZ_HALF: begin
        be = 4'b0011 << {cap_addr[1], 1'b0};
        wd = {2{cap_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign mem.req   = in_req;
  assign mem.we    = in_req && !cap_is_load;
  assign mem.addr  = in_req ? {cap_addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem.be    = in_req ? be : 4'h0;
  assign mem.wdata = in_req ? wd : 32'h0;

  load_align u_load_align (
    .rdata  (mem.rdata),
    .lane   (cap_addr[1:0]),
    .funct3 (cap_f3),
    .data   (ld_aligned)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      cap_addr  <= '0;
      cap_wdata <= 32'h0;
      cap_f3    <= 3'b000;
      cap_size  <= 2'b00;
      load_data <= 32'h0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cap_addr  <= addr;
        cap_wdata <= wdata;
        cap_f3    <= funct3;
        cap_size  <= store_size;
      end
      if (in_req && mem.ack && cap_is_load) load_data <= ld_aligned;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases followed by
// randomized accesses compared against a byte-lane arithmetic reference model.
module tb_load_store_unit;

  logic        CLK;
  logic        RST_N;
  logic        memory_en;
  logic [1:0]  store_size;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] ld_model = 32'h0;

  load_store_unit_if #(.ADDR_W(32)) mem_bus ();

  load_store_unit #(.ADDR_W(32)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .memory_en  (memory_en),
    .store_size (store_size),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .misaligned (misaligned),
    .mem        (mem_bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz, input logic [2:0] f3);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    if (sz == 2'b10) return 4;
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int     n;
    int     off;
    longint v;
    n   = nbytes(2'b11, f3);
    off = int'(a[1:0]);
    v   = (longint'(rd) >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
    if ((f3 == 3'b000 || f3 == 3'b001) && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_lvalid"}, 32'(load_valid), 32'd0);
    chk({tag, "_misal"}, 32'(misaligned), 32'd0);
    chk({tag, "_req"}, 32'(mem_bus.req), 32'd0);
    chk({tag, "_we"}, 32'(mem_bus.we), 32'd0);
    chk({tag, "_be"}, 32'(mem_bus.be), 32'd0);
    chk({tag, "_addr"}, mem_bus.addr, 32'd0);
    chk({tag, "_wdata"}, mem_bus.wdata, 32'd0);
  endtask

  // Starts and ends just after a rising edge with the DUT in IDLE.
  task automatic run_access(input logic [1:0] sz, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int ack_wait, input logic [31:0] rd);
    int          n;
    logic        is_ld;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    n     = nbytes(sz, f3);
    is_ld = (sz == 2'b11);
    exp_be = is_ld ? 4'hF : 4'(((1 << n) - 1) << int'(a[1:0]));
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];

    memory_en = 1'b1; store_size = sz; funct3 = f3; addr = a; wdata = wd;
    mem_bus.ack = 1'b0;
    @(negedge CLK);
    if ((int'(a[1:0]) % n) != 0) begin
      chk("misal_pulse", 32'(misaligned), 32'd1);
      chk("misal_stall", 32'(stall), 32'd0);
      chk("misal_req", 32'(mem_bus.req), 32'd0);
      @(posedge CLK); #1;
      memory_en = 1'b0;
      @(negedge CLK);
      chk("misal_end", 32'(misaligned), 32'd0);
      chk("misal_req2", 32'(mem_bus.req), 32'd0);
      @(posedge CLK); #1;
      return;
    end
    chk("accept_stall", 32'(stall), 32'd1);
    chk("accept_req", 32'(mem_bus.req), 32'd0);
    chk("accept_misal", 32'(misaligned), 32'd0);

    for (int w = 0; w <= ack_wait; w++) begin
      @(posedge CLK); #1;
      memory_en   = 1'($urandom);
      store_size  = 2'($urandom);
      funct3      = 3'($urandom);
      addr        = $urandom;
      wdata       = $urandom;
      mem_bus.ack = (w == ack_wait);
      mem_bus.rdata = (w == ack_wait) ? rd : $urandom;
      @(negedge CLK);
      chk("req_req", 32'(mem_bus.req), 32'd1);
      chk("req_stall", 32'(stall), 32'd1);
      chk("req_we", 32'(mem_bus.we), 32'(!is_ld));
      chk("req_addr", mem_bus.addr, {a[31:2], 2'b00});
      chk("req_be", 32'(mem_bus.be), 32'(exp_be));
      if (!is_ld) chk("req_wdata", mem_bus.wdata, exp_wd);
      chk("req_lvalid", 32'(load_valid), 32'd0);
    end

    @(posedge CLK); #1;
    mem_bus.ack   = 1'($urandom);
    mem_bus.rdata = $urandom;
    memory_en     = 1'($urandom);
    addr          = $urandom;
    if (is_ld) ld_model = model_load(f3, a, rd);
    @(negedge CLK);
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_lvalid", 32'(load_valid), 32'(is_ld));
    chk("done_misal", 32'(misaligned), 32'd0);
    chk("done_req", 32'(mem_bus.req), 32'd0);
    chk("done_ldata", load_data, ld_model);

    @(posedge CLK); #1;
    memory_en   = 1'b0;
    mem_bus.ack = 1'b0;
    @(negedge CLK);
    chk("post_lvalid", 32'(load_valid), 32'd0);
    chk("post_stall", 32'(stall), 32'd0);
    chk("post_req", 32'(mem_bus.req), 32'd0);
    chk("post_ldata", load_data, ld_model);
    @(posedge CLK); #1;
  endtask

  task automatic reset_mid_req();
    memory_en = 1'b1; store_size = 2'b11; funct3 = 3'b010; addr = 32'h300;
    mem_bus.ack = 1'b0;
    @(posedge CLK); #1;
    memory_en = 1'b0;
    RST_N = 1'b0;
    @(negedge CLK);
    chk("rst_req_before", 32'(mem_bus.req), 32'd1);
    chk("rst_stall_low", 32'(stall), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    mem_bus.ack = 1'b1;
    mem_bus.rdata = 32'h1234_5678;
    ld_model = 32'h0;
    @(negedge CLK);
    check_idle_outputs("rst_mid");
    chk("rst_mid_ldata", load_data, 32'h0);
    @(posedge CLK); #1;
    mem_bus.ack = 1'b0;
    @(negedge CLK);
    chk("rst_late_lvalid", 32'(load_valid), 32'd0);
    chk("rst_late_req", 32'(mem_bus.req), 32'd0);
    chk("rst_late_ldata", load_data, 32'h0);
    @(posedge CLK); #1;
  endtask

  initial begin
    RST_N = 1'b0; memory_en = 1'b1; store_size = 2'b11; funct3 = 3'b010;
    addr = 32'h0; wdata = 32'h0;
    mem_bus.ack = 1'b0; mem_bus.rdata = 32'h0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_idle_outputs("reset");
    chk("reset_ldata", load_data, 32'h0);
    @(posedge CLK); #1;
    memory_en = 1'b0;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    run_access(2'b11, 3'b010, 32'h100, 32'h0, 1, 32'hDEAD_BEEF);
    chk("lw_dir_model", ld_model, 32'hDEAD_BEEF);
    run_access(2'b11, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_0011);
    chk("lb_dir_model", ld_model, 32'hFFFF_FF80);
    run_access(2'b11, 3'b100, 32'h103, 32'h0, 0, 32'h80FF_0011);
    chk("lbu_dir_model", ld_model, 32'h0000_0080);
    run_access(2'b01, 3'b000, 32'h202, 32'h0000_ABCD, 0, 32'h0);
    run_access(2'b11, 3'b010, 32'h101, 32'h0, 0, 32'h0);
    run_access(2'b11, 3'b001, 32'h402, 32'h0, 10, 32'h8001_7FFF);
    run_access(2'b10, 3'b000, 32'h404, 32'h1122_3344, 10, 32'h0);
    run_access(2'b11, 3'b101, 32'h406, 32'h0, 2, 32'hF00D_1234);
    run_access(2'b00, 3'b000, 32'h501, 32'hFFFF_FF5A, 0, 32'h0);
    run_access(2'b10, 3'b000, 32'h502, 32'h0, 0, 32'h0);
    reset_mid_req();

    for (int k = 0; k < 300; k++) begin
      run_access(2'($urandom), 3'($urandom), $urandom, $urandom,
                 int'($urandom_range(0, 3)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
